// File: rtl/cdc_fifo_rptr_empty.sv
// Read-side pointer and empty/almost-empty flag logic for an async FIFO.
// Optional readable-entry count port is enabled by the CDC_FIFO_RPTR_COUNT_EN macro.
module cdc_fifo_rptr_empty #(
    parameter int ADDR_SIZE = 4
) (
    input  logic                 r_clk,
    input  logic                 r_rst,
    input  logic                 r_inc,
    input  logic [ADDR_SIZE:0]   r_q2_wptr,
    output logic                 r_empty,
    output logic                 r_almost_empty,
    output logic [ADDR_SIZE:0]   r_ptr,
    output logic [ADDR_SIZE-1:0] r_addr
`ifdef CDC_FIFO_RPTR_COUNT_EN
    ,
    output logic [ADDR_SIZE:0]   r_count
`endif
);

    localparam logic [ADDR_SIZE:0] PTR_ONE  = {{ADDR_SIZE{1'b0}}, 1'b1};
    localparam logic [ADDR_SIZE:0] PTR_ZERO = '0;

    function automatic logic [ADDR_SIZE:0] bin2gray(input logic [ADDR_SIZE:0] b);
        return b ^ (b >> 1);
    endfunction

`ifdef CDC_FIFO_RPTR_COUNT_EN
    function automatic logic [ADDR_SIZE:0] gray2bin(input logic [ADDR_SIZE:0] g);
        logic [ADDR_SIZE:0] b;
        b[ADDR_SIZE] = g[ADDR_SIZE];
        for (int i = ADDR_SIZE - 1; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction
`endif

    logic [ADDR_SIZE:0] r_bin;
    logic [ADDR_SIZE:0] bin_next;
    logic [ADDR_SIZE:0] bin_next_plus1;
    logic               rd_en;

    // A read is only honoured while the FIFO is not already flagged empty.
    assign rd_en          = r_inc & ~r_empty;
    assign bin_next       = rd_en ? (r_bin + PTR_ONE) : r_bin;
    assign bin_next_plus1 = bin_next + PTR_ONE;
    assign r_addr         = r_bin[ADDR_SIZE-1:0];

    always_ff @(posedge r_clk) begin
        if (r_rst) begin
            r_bin          <= PTR_ZERO;
            r_ptr          <= PTR_ZERO;
            r_empty        <= 1'b1;
            r_almost_empty <= 1'b0;
        end else begin
            r_bin          <= bin_next;
            r_ptr          <= bin2gray(bin_next);
            r_empty        <= (bin2gray(bin_next) == r_q2_wptr);
            r_almost_empty <= (bin2gray(bin_next_plus1) == r_q2_wptr);
        end
    end

`ifdef CDC_FIFO_RPTR_COUNT_EN
    // Modular difference of pointers gives occupancy across lap boundaries.
    always_ff @(posedge r_clk) begin
        if (r_rst) begin
            r_count <= PTR_ZERO;
        end else begin
            r_count <= gray2bin(r_q2_wptr) - bin_next;
        end
    end
`endif

endmodule

// File: doc/cdc_fifo_rptr_empty.md
CDC_FIFO_RPTR_EMPTY -- requirements
Module: cdc_fifo_rptr_empty

Interface
REQ-001 The block SHALL have parameter ADDR_SIZE, default 4, meaning log2 of FIFO depth; pointers are ADDR_SIZE+1 bits wide.
REQ-002 The block SHALL have r_clk  input  1  read-domain clock; the block has one clock only.
REQ-003 The block SHALL have r_rst  input  1  reset, synchronous, active-high.
REQ-004 The block SHALL have r_inc  input  1  read request for the current cycle.
REQ-005 The block SHALL have r_q2_wptr  input  ADDR_SIZE+1  write pointer, Gray-coded, already 2-flop synchronized into r_clk.
REQ-006 The block SHALL have r_empty  output  1  registered FIFO-empty flag.
REQ-007 The block SHALL have r_almost_empty  output  1  registered flag: exactly one entry readable.
REQ-008 The block SHALL have r_ptr  output  ADDR_SIZE+1  registered Gray read pointer, for synchronization into the write domain.
REQ-009 The block SHALL have r_addr  output  ADDR_SIZE  RAM read address, equal to the low ADDR_SIZE bits of the binary read pointer.
REQ-010 The block SHALL have r_count  output  ADDR_SIZE+1  readable-entry count; the port is present only under CDC_FIFO_RPTR_COUNT_EN.

Function
REQ-011 The block SHALL keep an internal binary pointer r_bin; r_bin_next = r_bin + (r_inc AND NOT r_empty), modulo 2^(ADDR_SIZE+1).
REQ-012 On each r_clk edge the block SHALL load r_bin <= r_bin_next and r_ptr <= r_bin_next XOR (r_bin_next >> 1).
REQ-013 r_addr SHALL equal r_bin[ADDR_SIZE-1:0] combinationally, so it addresses the entry at the head of the FIFO.
REQ-014 The block SHALL register r_empty <= (Gray(r_bin_next) == r_q2_wptr), so empty asserts in the cycle after the last read.
REQ-015 The block SHALL register r_almost_empty <= (Gray(r_bin_next + 1) == r_q2_wptr); it is therefore never high while r_empty is high.
REQ-016 While r_empty = 1, r_inc SHALL be ignored: r_bin, r_ptr and r_addr hold.
REQ-017 A change on r_q2_wptr SHALL clear r_empty one r_clk edge after it is sampled; there is no other latency.
REQ-018 If a read occurs in the same cycle as r_q2_wptr advances, the block SHALL evaluate both against r_bin_next in that cycle; no event is lost.
REQ-019 Pointer wrap from 2^(ADDR_SIZE+1)-1 to 0 SHALL be seamless; the MSB difference distinguishes laps.

Reset
REQ-020 While r_rst = 1 at an r_clk edge, the block SHALL set r_bin = 0, r_ptr = 0, r_empty = 1, r_almost_empty = 0 and r_count = 0; r_addr is then 0.
REQ-021 A reset asserted mid-operation SHALL take effect at the next edge regardless of r_inc, discarding the in-flight read.
REQ-022 On the first edge after reset release, flags SHALL be recomputed from r_q2_wptr per REQ-014/015.

Configuration
REQ-023 With macro CDC_FIFO_RPTR_COUNT_EN defined, the block SHALL convert r_q2_wptr from Gray to binary and register r_count <= (Gray2Bin(r_q2_wptr) - r_bin_next) modulo 2^(ADDR_SIZE+1), so r_count is 0 exactly when r_empty = 1.
REQ-024 Without CDC_FIFO_RPTR_COUNT_EN, the block SHALL omit the r_count port, the Gray-to-binary logic and the subtractor; all other behaviour is identical.

Verification (ADDR_SIZE = 4)
REQ-025 Reset with r_q2_wptr=0 -> r_empty=1, r_almost_empty=0, r_ptr=5'b00000, r_addr=4'b0000; r_inc=1 for 3 cycles leaves all values unchanged.
REQ-026 Set r_q2_wptr=5'b00110 (4 entries), then pulse r_inc 4 times with idle cycles between -> r_empty=0 before the first read; r_almost_empty=1 after the 3rd read; after the 4th read r_ptr=5'b00110, r_addr=4'b0100, r_empty=1, r_almost_empty=0.
REQ-027 Reset, set r_q2_wptr=5'b11000 (16 entries), hold r_inc=1 for 16 cycles -> r_almost_empty=1 after 15 reads; after 16 reads r_empty=1, r_ptr=5'b11000, r_addr=4'b0000; a 17th r_inc leaves r_ptr=5'b11000.
REQ-028 With 2 entries available, assert r_inc in the same cycle that r_q2_wptr advances by 1 -> r_empty=0, r_almost_empty=0, r_addr advanced by 1.
REQ-029 After 2 reads, assert r_rst for 1 cycle while r_inc=1 -> r_ptr=0, r_addr=0, r_empty=1 at the next edge; flags follow r_q2_wptr after release.
REQ-030 With CDC_FIFO_RPTR_COUNT_EN defined, r_q2_wptr=5'b00110 and 1 read completed -> r_count=3; after 4 reads -> r_count=0 together with r_empty=1.
